// File: rtl/mem_access_stage.sv
// RV32I memory stage: issues loads/stores over a req/ready bus, steers byte lanes,
// extends load data and drives the MEM/WB pipeline register.
module mem_access_stage #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RegWriteM,
    input  logic        ResultSrcM,
    input  logic        MemWriteM,
    input  logic [2:0]  funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [4:0]  RdM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        StallM,
    output logic        RegWriteW,
    output logic        ResultSrcW,
    output logic [31:0] ALUResultW,
    output logic [31:0] ReadDataW,
    output logic [4:0]  RdW,
    output logic        misaligned,
    output logic        bus_err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [31:0] TO_LAST = TIMEOUT - 32'd1;

    logic [1:0]  state_r;
    logic [31:0] wait_cnt_r;
    logic [31:0] rdata_r;
    logic        timed_out_r;

    logic access_s;
    logic mis_s;
    logic go_s;
    logic timeout_s;

    function automatic logic addr_misaligned(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b01:   return a[0];
            2'b10:   return (a != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   return 4'b0001 << a;
            2'b01:   return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [2:0] f3,
                                                input logic [1:0] a);
        logic [31:0] sh;
        sh = w >> {a, 3'b000};
        case (f3)
            3'b000:  return {{24{sh[7]}}, sh[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b100:  return {24'd0, sh[7:0]};
            3'b101:  return {16'd0, sh[15:0]};
            default: return w;
        endcase
    endfunction

    // Access classification and stall; ready arriving with the timeout counts as success
    always_comb begin
        access_s  = ResultSrcM | MemWriteM;
        mis_s     = addr_misaligned(funct3M, ALUResultM[1:0]);
        go_s      = access_s & ~mis_s;
        StallM    = go_s & (state_r != DONE);
        timeout_s = (state_r == REQ) & ~mem_ready & (TIMEOUT != 0) & (wait_cnt_r == TO_LAST);
    end

    // Bus FSM: the request is registered so bus signals stay stable for the whole REQ phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= 32'd0;
            mem_wdata   <= 32'd0;
            mem_be      <= 4'd0;
            wait_cnt_r  <= 32'd0;
            rdata_r     <= 32'd0;
            timed_out_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (go_s) begin
                        state_r     <= REQ;
                        mem_req     <= 1'b1;
                        mem_we      <= MemWriteM;
                        mem_addr    <= {ALUResultM[31:2], 2'b00};
                        mem_be      <= MemWriteM ? store_be(funct3M, ALUResultM[1:0]) : 4'b1111;
                        mem_wdata   <= MemWriteM ? store_data(funct3M, WriteDataM) : 32'd0;
                        wait_cnt_r  <= 32'd0;
                        timed_out_r <= 1'b0;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                REQ: begin
                    if (mem_ready) begin
                        rdata_r <= mem_rdata;
                        mem_req <= 1'b0;
                        state_r <= DONE;
                    end else if (timeout_s) begin
                        timed_out_r <= 1'b1;
                        mem_req     <= 1'b0;
                        state_r     <= DONE;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 32'd1;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

    // MEM/WB register plus event pulses; a stalled cycle emits a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegWriteW  <= 1'b0;
            ResultSrcW <= 1'b0;
            ALUResultW <= 32'd0;
            ReadDataW  <= 32'd0;
            RdW        <= 5'd0;
            misaligned <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            misaligned <= access_s & mis_s;
            bus_err    <= timeout_s;
            if (StallM) begin
                RegWriteW  <= 1'b0;
                ResultSrcW <= 1'b0;
                ALUResultW <= 32'd0;
                ReadDataW  <= 32'd0;
                RdW        <= 5'd0;
            end else begin
                RegWriteW  <= RegWriteM & ~(access_s & mis_s) & ~(go_s & timed_out_r);
                ResultSrcW <= ResultSrcM;
                ALUResultW <= ALUResultM;
                RdW        <= RdM;
                ReadDataW  <= (ResultSrcM & ~mis_s & ~timed_out_r)
                              ? load_extend(rdata_r, funct3M, ALUResultM[1:0]) : 32'd0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with TIMEOUT = 4; expected values are hand-computed.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        RegWriteM = 1'b0, ResultSrcM = 1'b0, MemWriteM = 1'b0;
    logic [2:0]  funct3M = 3'd0;
    logic [31:0] ALUResultM = 32'd0, WriteDataM = 32'd0;
    logic [4:0]  RdM = 5'd0;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        StallM, RegWriteW, ResultSrcW;
    logic [31:0] ALUResultW, ReadDataW;
    logic [4:0]  RdW;
    logic        misaligned, bus_err;

    int checks = 0;
    int errors = 0;

    mem_access_stage #(.TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
        .funct3M(funct3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .RdM(RdM),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .StallM(StallM), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
        .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .RdW(RdW),
        .misaligned(misaligned), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_nop();
        RegWriteM = 1'b0; ResultSrcM = 1'b0; MemWriteM = 1'b0;
        funct3M = 3'd0; ALUResultM = 32'd0; WriteDataM = 32'd0; RdM = 5'd0;
        mem_ready = 1'b0;
    endtask

    // Drives one memory instruction from a negedge; ready_cycle = REQ cycle with ready (0 = never)
    task automatic do_mem(input logic ld, input logic st, input logic rw, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                          input logic [31:0] rdata, input int ready_cycle,
                          output int stalls, output logic req1, output logic we1,
                          output logic [31:0] addr1, output logic [31:0] wdata1,
                          output logic [3:0] be1, output logic berr, output logic req_done);
        bit done = 0;
        RegWriteM = rw; ResultSrcM = ld; MemWriteM = st; funct3M = f3;
        ALUResultM = addr; WriteDataM = wd; RdM = rd; mem_rdata = rdata; mem_ready = 1'b0;
        stalls = 0; berr = 1'b0; req_done = 1'b1;
        req1 = 1'b0; we1 = 1'b0; addr1 = 32'd0; wdata1 = 32'd0; be1 = 4'd0;
        #1;
        if (StallM) stalls = 1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 1) begin
                req1 = mem_req; we1 = mem_we; addr1 = mem_addr; wdata1 = mem_wdata; be1 = mem_be;
            end
            if (!StallM) begin
                berr = bus_err; req_done = mem_req; done = 1;
                break;
            end
            stalls++;
            mem_ready = (k == ready_cycle);
        end
        if (!done) check("stall_bound", 32'd1, 32'd0);
        mem_ready = 1'b0;
        @(negedge clk);
    endtask

    int          st_n;
    logic        r1, w1, be_err, rq_d;
    logic [31:0] a1, wd1;
    logic [3:0]  b1;

    initial begin
        set_nop();
        #12;
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_stall", 32'(StallM), 32'd0);
        check("rst_regwrite", 32'(RegWriteW), 32'd0);
        check("rst_rdata", ReadDataW, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // LW 0x100, ready in first REQ cycle
        do_mem(1, 0, 1, 3'b010, 32'h100, 32'd0, 5'd5, 32'hDEADBEEF, 1, st_n, r1, w1, a1, wd1, b1, be_err, rq_d);
        check("lw_stalls", 32'(st_n), 32'd2);
        check("lw_req", 32'(r1), 32'd1);
        check("lw_addr", a1, 32'h100);
        check("lw_we", 32'(w1), 32'd0);
        check("lw_req_done", 32'(rq_d), 32'd0);
        check("lw_data", ReadDataW, 32'hDEADBEEF);
        check("lw_regwrite", 32'(RegWriteW), 32'd1);
        check("lw_rd", 32'(RdW), 32'd5);
        check("lw_resultsrc", 32'(ResultSrcW), 32'd1);
        set_nop();

        // SB 0x203
        do_mem(0, 1, 0, 3'b000, 32'h203, 32'h000000A5, 5'd0, 32'd0, 1, st_n, r1, w1, a1, wd1, b1, be_err, rq_d);
        check("sb_be", 32'(b1), 32'h8);
        check("sb_wdata", wd1, 32'hA5A5A5A5);
        check("sb_we", 32'(w1), 32'd1);
        check("sb_addr", a1, 32'h200);
        check("sb_regwrite", 32'(RegWriteW), 32'd0);
        set_nop();

        // SH 0x2 and SW 0x8 lane steering
        do_mem(0, 1, 0, 3'b001, 32'h2, 32'hFFFF1234, 5'd0, 32'd0, 1, st_n, r1, w1, a1, wd1, b1, be_err, rq_d);
        check("sh_be", 32'(b1), 32'hC);
        check("sh_wdata", wd1, 32'h12341234);
        set_nop();
        do_mem(0, 1, 0, 3'b010, 32'h8, 32'hCAFEF00D, 5'd0, 32'd0, 1, st_n, r1, w1, a1, wd1, b1, be_err, rq_d);
        check("sw_be", 32'(b1), 32'hF);
        check("sw_wdata", wd1, 32'hCAFEF00D);
        set_nop();

        // Load extension
        do_mem(1, 0, 1, 3'b000, 32'h2, 32'd0, 5'd3, 32'h00800000, 1, st_n, r1, w1, a1, wd1, b1, be_err, rq_d);
        check("lb_data", ReadDataW, 32'hFFFFFF80);
        set_nop();
        do_mem(1, 0, 1, 3'b100, 32'h2, 32'd0, 5'd3, 32'h00800000, 1, st_n, r1, w1, a1, wd1, b1, be_err, rq_d);
        check("lbu_data", ReadDataW, 32'h00000080);
        set_nop();
        do_mem(1, 0, 1, 3'b001, 32'h2, 32'd0, 5'd3, 32'h80010000, 1, st_n, r1, w1, a1, wd1, b1, be_err, rq_d);
        check("lh_data", ReadDataW, 32'hFFFF8001);
        set_nop();

        // Misaligned LW 0x102
        RegWriteM = 1'b1; ResultSrcM = 1'b1; funct3M = 3'b010; ALUResultM = 32'h102; RdM = 5'd9;
        #1;
        check("mis_stall", 32'(StallM), 32'd0);
        @(negedge clk);
        check("mis_pulse", 32'(misaligned), 32'd1);
        check("mis_req", 32'(mem_req), 32'd0);
        check("mis_regwrite", 32'(RegWriteW), 32'd0);
        check("mis_rd", 32'(RdW), 32'd9);
        set_nop();
        @(negedge clk);
        check("mis_pulse_end", 32'(misaligned), 32'd0);

        // Timeout with no ready, then ready on REQ cycle 4
        do_mem(1, 0, 1, 3'b010, 32'h10, 32'd0, 5'd4, 32'h11112222, 0, st_n, r1, w1, a1, wd1, b1, be_err, rq_d);
        check("to_stalls", 32'(st_n), 32'd5);
        check("to_bus_err", 32'(be_err), 32'd1);
        check("to_req_drop", 32'(rq_d), 32'd0);
        check("to_regwrite", 32'(RegWriteW), 32'd0);
        check("to_bus_err_end", 32'(bus_err), 32'd0);
        set_nop();
        do_mem(1, 0, 1, 3'b010, 32'h10, 32'd0, 5'd4, 32'h11112222, 4, st_n, r1, w1, a1, wd1, b1, be_err, rq_d);
        check("late_stalls", 32'(st_n), 32'd5);
        check("late_bus_err", 32'(be_err), 32'd0);
        check("late_regwrite", 32'(RegWriteW), 32'd1);
        check("late_data", ReadDataW, 32'h11112222);
        set_nop();

        // Reset during REQ, then ADD passes through
        RegWriteM = 1'b1; ResultSrcM = 1'b1; funct3M = 3'b010; ALUResultM = 32'h40; RdM = 5'd6;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_req", 32'(mem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_req", 32'(mem_req), 32'd0);
        check("rst_mid_regwrite", 32'(RegWriteW), 32'd0);
        check("rst_mid_rd", 32'(RdW), 32'd0);
        @(negedge clk);
        set_nop();
        rst_n = 1'b1;
        @(negedge clk);
        RegWriteM = 1'b1; ALUResultM = 32'h1234; RdM = 5'd7;
        #1;
        check("add_stall", 32'(StallM), 32'd0);
        @(negedge clk);
        check("add_regwrite", 32'(RegWriteW), 32'd1);
        check("add_rd", 32'(RdW), 32'd7);
        check("add_alu", ALUResultW, 32'h1234);
        check("add_req", 32'(mem_req), 32'd0);
        set_nop();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory (M) stage of the 5-stage RISC-V pipeline; consumes the EX/MEM register outputs and drives the MEM/WB register.
- Performs RV32I loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) over a req/ready data bus, with byte-lane steering and load extension.
- Stalls the pipeline while a bus access is outstanding, and flags misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT, 255, maximum cycles mem_req may stay high without mem_ready before the access aborts; 0 disables the timeout.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  reset
- RegWriteM  in  1  register write enable from EX/MEM
- ResultSrcM  in  1  1 = load; result is memory data
- MemWriteM  in  1  store
- funct3M  in  3  access size/sign (RV32I encoding)
- ALUResultM  in  32  effective address or ALU result
- WriteDataM  in  32  store data (rs2)
- RdM  in  5  destination register
- mem_req  out  1  bus request
- mem_we  out  1  bus write
- mem_addr  out  32  word-aligned address
- mem_wdata  out  32  lane-steered write data
- mem_be  out  4  byte enables
- mem_ready  in  1  bus completion
- mem_rdata  in  32  bus read word
- StallM  out  1  freeze IF/ID/EX and EX/MEM
- RegWriteW  out  1  to WB
- ResultSrcW  out  1  to WB
- ALUResultW  out  32  to WB
- ReadDataW  out  32  extended load data
- RdW  out  5  to WB
- misaligned  out  1  one-cycle pulse: misaligned access
- bus_err  out  1  one-cycle pulse: timeout

Behaviour:
- Interface: one clock (clk); reset (rst_n) is asynchronous and active-low. Reset clears all outputs and registers to 0 and forces the FSM to IDLE. Reset mid-access abandons the access and drops mem_req.
- access = ResultSrcM | MemWriteM.
- Misaligned when funct3[1:0] = 01 and addr[0] = 1, or when funct3[1:0] = 10 and addr[1:0] != 0.
- Misaligned access:
  - No bus request is issued.
  - misaligned pulses for one cycle; StallM stays 0.
  - MEM/WB captures the instruction with RegWriteW forced to 0.
- FSM states: IDLE, REQ, DONE.
  - IDLE: aligned access -> register mem_addr = {addr[31:2], 00}, mem_we, mem_be and mem_wdata; go to REQ. Otherwise stay in IDLE.
  - REQ: mem_req = 1 and bus signals held stable. On mem_ready, capture mem_rdata and go to DONE. If TIMEOUT != 0 and the wait counter reaches TIMEOUT, pulse bus_err, drop the request and go to DONE with RegWriteW forced to 0.
  - DONE: one cycle, then IDLE. No new request may start in DONE.
- StallM = access & aligned & (state != DONE). Minimum access latency is 3 cycles (IDLE, REQ, DONE) with zero bus wait states.
- Store lanes:
  - SB: be = 1 << addr[1:0]; wdata = byte replicated x4.
  - SH: be = 0011 (addr[1] = 0) or 1100 (addr[1] = 1); wdata = halfword replicated x2.
  - SW: be = 1111; wdata unchanged.
- Load: select the lane by addr[1:0]. LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word. ReadDataW = 0 for non-loads.
- MEM/WB register:
  - When StallM = 0: ResultSrcW, ALUResultW, RdW and RegWriteW take the M values, with the forcing rules above applied.
  - When StallM = 1: a bubble is inserted (RegWriteW = 0, RdW = 0, ResultSrcW = 0).
- mem_ready outside REQ is ignored. mem_ready in the same cycle the timeout expires counts as success; bus_err is not asserted.
- Back-to-back memory instructions each take the full IDLE->REQ->DONE sequence.
- Non-memory instructions pass through with 1-cycle latency and no stall.

Test Plan:
- LW at addr 0x100, mem_rdata = 0xDEADBEEF, mem_ready on the first REQ cycle -> StallM high 2 cycles, mem_addr 0x100, ReadDataW = 0xDEADBEEF, RegWriteW = 1, RdW correct.
- SB at addr 0x203, data 0x000000A5 -> mem_be = 1000, mem_wdata = 0xA5A5A5A5, mem_we = 1, RegWriteW = 0.
- LB / LBU at addr 0x2 with rdata 0x00800000 -> 0xFFFFFF80 / 0x00000080. LH at addr 0x2 with rdata 0x80010000 -> 0xFFFF8001.
- LW at 0x102 -> misaligned pulses, mem_req stays 0, StallM 0, RegWriteW 0.
- TIMEOUT = 4, mem_ready never asserted -> bus_err after 4 REQ cycles, stall released, RegWriteW 0. Repeat with mem_ready on cycle 4 -> success, no bus_err.
- rst_n low during REQ -> mem_req 0 immediately, all W outputs 0; ADD (RegWriteM = 1, no access) after release -> RegWriteW = 1 next cycle, no stall.
